// File: rtl/post_processing.sv
// Montgomery-domain exit: out = X * 2^-WIDTH mod N by WIDTH bit-serial halvings and a final fixup.
// Optional input checking (N even or X >= N flags err) is enabled with `define POST_INPUT_CHECK_EN.
module post_processing #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             beg,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] N,
    output logic [WIDTH-1:0] out,
    output logic             out_ready,
`ifdef POST_INPUT_CHECK_EN
    output logic             err,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        HALVE = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           cur, nxt;
    logic [WIDTH:0]   acc, acc_nxt, sum, n_ext;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ready_nxt;
    logic             bad_input;

`ifdef POST_INPUT_CHECK_EN
    logic err_nxt;
    assign bad_input = ~N[0] | (X >= N);
`else
    assign bad_input = 1'b0;
`endif

    assign n_ext = {1'b0, N};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur       <= LOAD;
            acc       <= '0;
            cnt       <= '0;
            out_ready <= 1'b0;
`ifdef POST_INPUT_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            cur       <= nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_ready <= ready_nxt;
`ifdef POST_INPUT_CHECK_EN
            err       <= err_nxt;
`endif
        end
    end

    always_comb begin
        nxt = cur;
        if (!beg) begin
            nxt = LOAD;
        end else begin
            case (cur)
                LOAD:    nxt = bad_input ? DONE : HALVE;
                HALVE:   nxt = (cnt == LAST) ? FIXUP : HALVE;
                FIXUP:   nxt = DONE;
                default: nxt = DONE;
            endcase
        end
    end

    // Datapath next values; acc stays below 2N during HALVE, so WIDTH+1 bits never overflow.
    always_comb begin
        sum       = acc + (acc[0] ? n_ext : '0);
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ready_nxt = 1'b0;
`ifdef POST_INPUT_CHECK_EN
        err_nxt   = err;
`endif
        if (!beg) begin
            acc_nxt = {1'b0, X};
            cnt_nxt = '0;
`ifdef POST_INPUT_CHECK_EN
            err_nxt = 1'b0;
`endif
        end else begin
            case (cur)
                LOAD: begin
                    if (bad_input) begin
                        acc_nxt   = '0;
                        ready_nxt = 1'b1;
`ifdef POST_INPUT_CHECK_EN
                        err_nxt   = 1'b1;
`endif
                    end
                end
                HALVE: begin
                    acc_nxt = sum >> 1;
                    cnt_nxt = cnt + 1'b1;
                end
                FIXUP: begin
                    if (acc >= n_ext) acc_nxt = acc - n_ext;
                    ready_nxt = 1'b1;
                end
                default: ready_nxt = 1'b0;
            endcase
        end
    end

    always_comb begin
        out   = acc[WIDTH-1:0];
        state = cur;
    end

endmodule
